// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory access, lane steering, load extension.
// Define LSU_TIMEOUT_EN to abort accesses that see no DM_ACK within TIMEOUT wait cycles.
module mem_stage_lsu #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  MEM_Opcode,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_ALU_RESULT,
  input  logic [31:0] MEM_RT_DATA,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_WDATA,
  input  logic        DM_ACK,
  input  logic [31:0] DM_RDATA,
  output logic [31:0] MEM_RD_DATA,
  output logic        MEM_Stall,
  output logic        MEM_Addr_Err,
  output logic        MEM_Bus_Err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic op_lb, op_lh, op_lw, op_lbu;
  logic op_lhu, op_sb, op_sh, op_sw;
  logic known, is_store, is_byte;
  logic is_half, is_word, acc, mis, go;
  logic tmo;
  logic [1:0]  a_lo;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] lane, fmt;
  logic [31:0] rd_q;
  logic [1:0]  off_q;
  logic        kb_q, kh_q, kw_q, sext_q;

  if (TIMEOUT >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT");
  end

  assign a_lo   = MEM_ALU_RESULT[1:0];
  assign op_lb  = MEM_Opcode == 6'h20;
  assign op_lh  = MEM_Opcode == 6'h21;
  assign op_lw  = MEM_Opcode == 6'h23;
  assign op_lbu = MEM_Opcode == 6'h24;
  assign op_lhu = MEM_Opcode == 6'h25;
  assign op_sb  = MEM_Opcode == 6'h28;
  assign op_sh  = MEM_Opcode == 6'h29;
  assign op_sw  = MEM_Opcode == 6'h2B;

  assign is_store = op_sb | op_sh | op_sw;
  assign is_byte  = op_lb | op_lbu | op_sb;
  assign is_half  = op_lh | op_lhu | op_sh;
  assign is_word  = op_lw | op_sw;
  assign known    = is_byte | is_half | is_word;
  assign acc      = known & (MEM_MemRead | MEM_MemWrite);
  assign mis      = (is_half & a_lo[0])
                  | (is_word & |a_lo);

  // Reset gates the handshake so a held EX/MEM access cannot stall
  assign go = RESET & (state_q == IDLE) & acc & ~mis;

  assign MEM_Addr_Err = RESET & (state_q == IDLE)
                      & acc & mis;
  assign MEM_Stall    = go | (state_q == WAIT);
  assign DM_REQ       = state_q == WAIT;
  assign MEM_RD_DATA  = (state_q == DONE) ? rd_q : '0;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = MEM_RT_DATA;
    unique case (1'b1)
      is_byte: begin
        be_d    = 4'b0001 << a_lo;
        wdata_d = {4{MEM_RT_DATA[7:0]}};
      end
      is_half: begin
        be_d    = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{MEM_RT_DATA[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = DM_RDATA >> {off_q, 3'b000};

  always_comb begin
    fmt = '0;
    unique case (1'b1)
      kb_q: fmt = {{24{sext_q & lane[7]}},
                   lane[7:0]};
      kh_q: fmt = {{16{sext_q & lane[15]}},
                   lane[15:0]};
      kw_q: fmt = lane;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = WAIT;
      WAIT: if (DM_ACK | tmo) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      DM_WE    <= 1'b0;
      DM_ADDR  <= '0;
      DM_BE    <= '0;
      DM_WDATA <= '0;
      off_q    <= '0;
      kb_q     <= 1'b0;
      kh_q     <= 1'b0;
      kw_q     <= 1'b0;
      sext_q   <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        DM_WE    <= is_store;
        DM_ADDR  <= {MEM_ALU_RESULT[31:2], 2'b00};
        DM_BE    <= be_d;
        DM_WDATA <= wdata_d;
        off_q    <= a_lo;
        kb_q     <= is_byte & ~is_store;
        kh_q     <= is_half & ~is_store;
        kw_q     <= op_lw;
        sext_q   <= op_lb | op_lh;
      end
      if (state_q == WAIT) begin
        if (DM_ACK) rd_q <= fmt;
        else if (tmo) rd_q <= '0;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             berr_q;

  assign tmo = (state_q == WAIT) & ~DM_ACK
             & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign MEM_Bus_Err = berr_q;

  // Counts WAIT cycles without ACK; the error pulse lands in DONE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      berr_q <= tmo;
      if (state_q != WAIT) cnt_q <= '0;
      else if (!DM_ACK) cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign MEM_Bus_Err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: byte-level reference memory,
// randomized accesses, decoupled responder and monitor.
module tb_mem_stage_lsu;

  logic        CLK;
  logic        RESET;
  logic [5:0]  MEM_Opcode;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [31:0] MEM_ALU_RESULT;
  logic [31:0] MEM_RT_DATA;
  logic        DM_REQ;
  logic        DM_WE;
  logic [31:0] DM_ADDR;
  logic [3:0]  DM_BE;
  logic [31:0] DM_WDATA;
  logic        DM_ACK;
  logic [31:0] DM_RDATA;
  logic [31:0] MEM_RD_DATA;
  logic        MEM_Stall;
  logic        MEM_Addr_Err;
  logic        MEM_Bus_Err;

  localparam int TMO = 15;

  mem_stage_lsu dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_Opcode(MEM_Opcode),
    .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite),
    .MEM_ALU_RESULT(MEM_ALU_RESULT),
    .MEM_RT_DATA(MEM_RT_DATA),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE),
    .DM_ADDR(DM_ADDR), .DM_BE(DM_BE),
    .DM_WDATA(DM_WDATA),
    .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
    .MEM_RD_DATA(MEM_RD_DATA),
    .MEM_Stall(MEM_Stall),
    .MEM_Addr_Err(MEM_Addr_Err),
    .MEM_Bus_Err(MEM_Bus_Err)
  );

  typedef struct {
    bit          err;
    bit          berr;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          stall;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];
  int   resp_q[$];
  logic [31:0] dmem [logic [31:0]];
  logic [7:0]  rmem [logic [31:0]];
  bit mon_en  = 0;
  bit resp_en = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, want);
    end
  endtask

  function automatic logic [31:0] fill(
      input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [7:0] rbyte(
      input logic [31:0] a);
    logic [31:0] w;
    if (rmem.exists(a)) return rmem[a];
    w = fill(a & ~32'h3);
    return w[8*int'(a % 4) +: 8];
  endfunction

  task automatic preload(input logic [31:0] a,
                         input logic [31:0] w);
    dmem[a & ~32'h3] = w;
    for (int i = 0; i < 4; i++)
      rmem[(a & ~32'h3) + i] = w[8*i +: 8];
  endtask

  // Opcode table: size in bytes, signedness, store
  task automatic decode(input logic [5:0] op,
                        output bit kn, output int sz,
                        output bit sg, output bit st);
    kn = 1; sz = 1; sg = 0; st = 0;
    case (op)
      6'h20: sg = 1;
      6'h21: begin sz = 2; sg = 1; end
      6'h23: sz = 4;
      6'h24: ;
      6'h25: sz = 2;
      6'h28: st = 1;
      6'h29: begin sz = 2; st = 1; end
      6'h2B: begin sz = 4; st = 1; end
      default: kn = 0;
    endcase
  endtask

  // d = WAIT cycles up to ACK; 0 = memory never answers
  task automatic issue(input logic [5:0] op,
                       input bit rd, input bit wr,
                       input logic [31:0] a,
                       input logic [31:0] rt,
                       input int d);
    bit kn, sg, st, s;
    int sz, n, k;
    exp_t e;
    logic [31:0] v;
    decode(op, kn, sz, sg, st);
    MEM_Opcode     = op;
    MEM_MemRead    = rd;
    MEM_MemWrite   = wr;
    MEM_ALU_RESULT = a;
    MEM_RT_DATA    = rt;
    if (kn && (rd || wr)) begin
      e = '{default: 0};
      if (a % sz != 0) e.err = 1;
      else begin
        k      = int'(a % 4);
        e.addr = a & ~32'h3;
        e.we   = st;
        for (int i = 0; i < sz; i++)
          e.be[k + i] = 1'b1;
        for (int j = 0; j < 4; j++)
          e.wdata[8*j +: 8] = rt[8*(j % sz) +: 8];
        if (d == 0) begin
          e.stall = 1 + TMO;
          e.berr  = 1;
        end else e.stall = 1 + d;
        if (st && d != 0) begin
          for (int i = 0; i < sz; i++)
            rmem[a + i] = rt[8*i +: 8];
        end else if (!st && d != 0) begin
          v = 0;
          for (int i = 0; i < sz; i++)
            v |= {24'b0, rbyte(a + i)} << (8*i);
          if (sg && v[8*sz-1])
            v |= ~((32'h1 << (8*sz)) - 1);
          e.rd = v;
        end
        resp_q.push_back(d);
      end
      exp_q.push_back(e);
    end
    n = 0;
    do begin
      @(negedge CLK);
      s = MEM_Stall;
      @(posedge CLK);
      #1;
      n++;
    end while (s && n < 400);
    if (s) chk("retire_bound", {31'b0, s}, 0);
  endtask

  // Memory responder: ACK after the requested wait, noise otherwise
  initial begin
    int wcnt, cur_d;
    logic [31:0] w;
    wcnt = 0; cur_d = 0;
    DM_ACK = 0; DM_RDATA = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (resp_en) begin
        DM_ACK   = 0;
        DM_RDATA = $urandom;
        if (!DM_REQ) begin
          wcnt   = 0;
          DM_ACK = ($urandom_range(0, 7) == 0);
        end else begin
          if (wcnt == 0)
            cur_d = (resp_q.size() > 0)
                  ? resp_q.pop_front() : 0;
          wcnt++;
          if (cur_d != 0 && wcnt == cur_d) begin
            if (!dmem.exists(DM_ADDR))
              dmem[DM_ADDR] = fill(DM_ADDR);
            w = dmem[DM_ADDR];
            DM_RDATA = w;
            if (DM_WE) begin
              for (int i = 0; i < 4; i++)
                if (DM_BE[i]) w[8*i +: 8] = DM_WDATA[8*i +: 8];
              dmem[DM_ADDR] = w;
            end
            DM_ACK = 1;
          end
        end
      end
    end
  end

  // Monitor: compares every observed cycle with the scoreboard head
  initial begin
    bit   prev_req;
    int   stall_cnt;
    exp_t e;
    prev_req = 0; stall_cnt = 0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (MEM_Stall) stall_cnt++;
        if (prev_req && !DM_REQ) begin
          if (exp_q.size() == 0)
            chk("sb_empty_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("done_stall", {31'b0, MEM_Stall}, 0);
            chk("rd_data", MEM_RD_DATA, e.rd);
            chk("stall_cycles", stall_cnt, e.stall);
            chk("bus_err", {31'b0, MEM_Bus_Err},
                {31'b0, e.berr});
          end
          stall_cnt = 0;
        end else if (DM_REQ) begin
          if (exp_q.size() == 0)
            chk("sb_empty_req", 1, 0);
          else begin
            e = exp_q[0];
            chk("req_ok", {31'b0, e.err}, 0);
            chk("dm_addr", DM_ADDR, e.addr);
            chk("dm_be", {28'b0, DM_BE}, {28'b0, e.be});
            chk("dm_we", {31'b0, DM_WE}, {31'b0, e.we});
            if (e.we) chk("dm_wdata", DM_WDATA, e.wdata);
            chk("wait_stall", {31'b0, MEM_Stall}, 1);
          end
        end else if (MEM_Addr_Err) begin
          if (exp_q.size() == 0)
            chk("sb_empty_err", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("addr_err_exp", {31'b0, e.err}, 1);
            chk("err_stall", {31'b0, MEM_Stall}, 0);
            chk("err_rd", MEM_RD_DATA, 0);
          end
          stall_cnt = 0;
        end else begin
          chk("idle_rd", MEM_RD_DATA, 0);
          chk("idle_berr", {31'b0, MEM_Bus_Err}, 0);
        end
        prev_req = DM_REQ;
      end
    end
  end

  initial begin
    logic [5:0] ops [10];
    logic [5:0] op;
    logic [31:0] a;
    bit kn, sg, st, rd, wr;
    int sz, r;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B, 6'h22, 6'h00};
    RESET = 1;
    MEM_Opcode = 0; MEM_MemRead = 0;
    MEM_MemWrite = 0; MEM_ALU_RESULT = 0;
    MEM_RT_DATA = 0;
    #1 RESET = 0;
    #2;
    chk("rst_req", {31'b0, DM_REQ}, 0);
    chk("rst_we", {31'b0, DM_WE}, 0);
    chk("rst_be", {28'b0, DM_BE}, 0);
    chk("rst_addr", DM_ADDR, 0);
    chk("rst_wdata", DM_WDATA, 0);
    chk("rst_rd", MEM_RD_DATA, 0);
    chk("rst_stall", {31'b0, MEM_Stall}, 0);
    chk("rst_errs", {30'b0, MEM_Addr_Err, MEM_Bus_Err}, 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1;
    mon_en = 1; resp_en = 1;

    preload(32'h100, 32'h800000FF);
    issue(6'h23, 1, 0, 32'h100, 0, 3);
    preload(32'h100, 32'h80123456);
    issue(6'h20, 1, 0, 32'h103, 0, 2);
    issue(6'h24, 1, 0, 32'h103, 0, 1);
    issue(6'h21, 1, 0, 32'h102, 0, 1);
    issue(6'h29, 0, 1, 32'h202, 32'h1234ABCD, 2);
    issue(6'h28, 0, 1, 32'h201, 32'h000000A5, 1);
    issue(6'h2B, 0, 1, 32'h204, 32'hCAFEF00D, 4);
    issue(6'h25, 1, 0, 32'h202, 0, 1);
    issue(6'h23, 1, 0, 32'h101, 0, 1);
    issue(6'h29, 0, 1, 32'h203, 32'h55, 1);
    issue(6'h23, 0, 0, 32'h100, 0, 1);
    issue(6'h22, 1, 0, 32'h100, 0, 1);
`ifdef LSU_TIMEOUT_EN
    issue(6'h23, 1, 0, 32'h104, 0, 0);
`else
    issue(6'h23, 1, 0, 32'h104, 0, 120);
`endif

    for (int it = 0; it < 250; it++) begin
      op = ops[$urandom_range(0, 9)];
      decode(op, kn, sz, sg, st);
      r = $urandom_range(0, 9);
      rd = 0; wr = 0;
      if (!kn) rd = 1'($urandom_range(0, 1));
      else if (r < 8) begin rd = !st; wr = st; end
      else if (r == 9) begin rd = 1; wr = 1; end
      a = 32'h180 + $urandom_range(0, 31);
      if ($urandom_range(0, 1)) a &= ~32'h3;
      issue(op, rd, wr, a, $urandom,
            $urandom_range(1, 5));
    end

    mon_en = 0; resp_en = 0; DM_ACK = 0;
    MEM_Opcode = 6'h23; MEM_MemRead = 1;
    MEM_MemWrite = 0; MEM_ALU_RESULT = 32'h40;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    chk("req_pre_reset", {31'b0, DM_REQ}, 1);
    RESET = 0;
    #1;
    chk("reset_req", {31'b0, DM_REQ}, 0);
    chk("reset_stall", {31'b0, MEM_Stall}, 0);
    chk("reset_be", {28'b0, DM_BE}, 0);
    MEM_Opcode = 0; MEM_MemRead = 0;
    @(posedge CLK); #1 RESET = 1;
    @(posedge CLK); #1;
    DM_ACK = 1; DM_RDATA = 32'hDEADBEEF;
    @(negedge CLK);
    chk("late_ack_req", {31'b0, DM_REQ}, 0);
    chk("late_ack_stall", {31'b0, MEM_Stall}, 0);
    @(posedge CLK); #1 DM_ACK = 0;
    @(negedge CLK);
    chk("late_ack_rd", MEM_RD_DATA, 0);
    chk("late_ack_req2", {31'b0, DM_REQ}, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
